picorv32_regs_dump: RTL and testbench

//  Read-side sequencer for the PicoRV32 register file: on request, walks x1..x31 (optionally x0)

---
 rtl/picorv32_regs_dump.sv | 118 +++++++++++
 tb/tb_picorv32_regs_dump.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_regs_dump.sv
// Register file dump sequencer: walks x1..LAST_IDX (optionally a synthetic x0)
// through the shared read port and streams each value on a valid/ready channel.
module picorv32_regs_dump #(
  parameter bit          INCLUDE_X0 = 1'b0,
  parameter int unsigned LAST_IDX   = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        rf_req,
  input  logic        rf_gnt,
  output logic [5:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [4:0]  m_idx,
  output logic        m_last
);

  localparam logic [4:0] LAST = 5'(LAST_IDX);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SEND,
    FIN
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  midx_q, midx_d;
  logic        last_q, last_d;

  // State and beat registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      data_q  <= 32'd0;
      midx_q  <= 5'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      midx_q  <= midx_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: abort beats grant and ready in every active state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    midx_d  = midx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (INCLUDE_X0) begin
            idx_d   = 5'd0;
            data_d  = 32'd0;
            midx_d  = 5'd0;
            last_d  = (LAST == 5'd0);
            state_d = SEND;
          end else begin
            idx_d   = 5'd1;
            state_d = ARB;
          end
        end
      end
      ARB: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rf_gnt) begin
          data_d  = rf_rdata;
          midx_d  = idx_q;
          last_d  = (idx_q == LAST);
          state_d = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (m_ready) begin
          if (last_q) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ARB;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign rf_req   = (state_q == ARB);
  assign rf_raddr = {1'b0, idx_q};
  assign m_valid  = (state_q == SEND);
  assign m_data   = data_q;
  assign m_idx    = midx_q;
  assign m_last   = last_q;

endmodule

// File: tb/tb_picorv32_regs_dump.sv
// Directed bench for the register dump sequencer.
// Main instance uses defaults; a second instance covers INCLUDE_X0/LAST_IDX=4.
module tb_picorv32_regs_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, abort, rf_gnt, m_ready;
  logic        busy, done, rf_req, m_valid, m_last;
  logic [5:0]  rf_raddr;
  logic [31:0] rf_rdata, m_data;
  logic [4:0]  m_idx;

  logic        start6, abort6, rf_gnt6, m_ready6;
  logic        busy6, done6, rf_req6, m_valid6, m_last6;
  logic [5:0]  rf_raddr6;
  logic [31:0] rf_rdata6, m_data6;
  logic [4:0]  m_idx6;

  logic [31:0] rf [32];

  assign rf_rdata  = rf[rf_raddr[4:0]];
  assign rf_rdata6 = rf[rf_raddr6[4:0]];

  int vecs = 0;
  int errs = 0;

  picorv32_regs_dump u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .rf_req(rf_req), .rf_gnt(rf_gnt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last)
  );

  picorv32_regs_dump #(.INCLUDE_X0(1'b1), .LAST_IDX(4)) u6 (
    .clk(clk), .reset(reset), .start(start6), .abort(abort6),
    .busy(busy6), .done(done6), .rf_req(rf_req6), .rf_gnt(rf_gnt6),
    .rf_raddr(rf_raddr6), .rf_rdata(rf_rdata6), .m_valid(m_valid6),
    .m_ready(m_ready6), .m_data(m_data6), .m_idx(m_idx6), .m_last(m_last6)
  );

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_dump(output bit to);
    int e;
    e = 0;
    while (busy && e < 200) begin
      @(negedge clk);
      e++;
    end
    to = busy;
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_req !== 1'b0) begin
      errs++;
      $display("FAIL reset ctl: busy %b done %b req %b, want 0 0 0",
               busy, done, rf_req);
    end
    vecs++;
    if (rf_raddr !== 6'd0 || m_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset rd: raddr %0d valid %b, want 0 0",
               rf_raddr, m_valid);
    end
    vecs++;
    if (m_data !== 32'd0 || m_idx !== 5'd0 || m_last !== 1'b0) begin
      errs++;
      $display("FAIL reset beat: data %h idx %0d last %b, want 0 0 0",
               m_data, m_idx, m_last);
    end
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vecs++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errs++;
      $display("FAIL idle abort: busy %b valid %b, want 0 0",
               busy, m_valid);
    end
  endtask

  task automatic test_full_dump();
    int e, beats;
    logic [4:0] exp;
    pulse_start();
    vecs++;
    if (busy !== 1'b1 || rf_req !== 1'b1 || rf_raddr !== 6'd1) begin
      errs++;
      $display("FAIL first arb: busy %b req %b raddr %0d, want 1 1 1",
               busy, rf_req, rf_raddr);
    end
    e = 0;
    beats = 0;
    exp = 5'd1;
    while (e < 100 && !done) begin
      if (m_valid) begin
        vecs++;
        if (m_idx !== exp || m_data !== rf[exp] ||
            m_last !== (exp == 5'd31)) begin
          errs++;
          $display("FAIL beat: idx %0d data %h last %b, want %0d %h %b",
                   m_idx, m_data, m_last, exp, rf[exp], exp == 5'd31);
        end
        beats++;
        exp = exp + 5'd1;
      end
      @(negedge clk);
      e++;
    end
    vecs++;
    if (done !== 1'b1 || e != 62) begin
      errs++;
      $display("FAIL done latency: done %b at %0d cycles, want 1 at 62",
               done, e);
    end
    vecs++;
    if (beats != 31) begin
      errs++;
      $display("FAIL beat count: %0d, want 31", beats);
    end
    @(negedge clk);
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL after done: done %b busy %b, want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int e;
    bit to;
    pulse_start();
    e = 0;
    while (e < 40 && !(m_valid && m_idx == 5'd3)) begin
      @(negedge clk);
      e++;
    end
    vecs++;
    if (!(m_valid === 1'b1 && m_idx === 5'd3)) begin
      errs++;
      $display("FAIL bp reach: valid %b idx %0d, want 1 3", m_valid, m_idx);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (m_valid !== 1'b1 || m_data !== 32'h1000_0003 ||
          m_idx !== 5'd3 || rf_req !== 1'b0) begin
        errs++;
        $display("FAIL bp hold: valid %b data %h idx %0d req %b, want 1 10000003 3 0",
                 m_valid, m_data, m_idx, rf_req);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (m_valid !== 1'b0 || rf_req !== 1'b1 || rf_raddr !== 6'd4) begin
      errs++;
      $display("FAIL bp next arb: valid %b req %b raddr %0d, want 0 1 4",
               m_valid, rf_req, rf_raddr);
    end
    @(negedge clk);
    vecs++;
    if (m_valid !== 1'b1 || m_idx !== 5'd4 || m_data !== 32'h1000_0004) begin
      errs++;
      $display("FAIL bp beat4: valid %b idx %0d data %h, want 1 4 10000004",
               m_valid, m_idx, m_data);
    end
    finish_dump(to);
    vecs++;
    if (to) begin
      errs++;
      $display("FAIL bp end: busy %b, want 0", busy);
    end
  endtask

  task automatic test_grant_stall();
    int e;
    bit to;
    pulse_start();
    e = 0;
    while (e < 40 && !(rf_req && rf_raddr == 6'd7)) begin
      @(negedge clk);
      e++;
    end
    vecs++;
    if (!(rf_req === 1'b1 && rf_raddr === 6'd7)) begin
      errs++;
      $display("FAIL gnt reach: req %b raddr %0d, want 1 7", rf_req, rf_raddr);
    end
    rf_gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vecs++;
      if (rf_req !== 1'b1 || rf_raddr !== 6'd7 || m_valid !== 1'b0) begin
        errs++;
        $display("FAIL gnt hold: req %b raddr %0d valid %b, want 1 7 0",
                 rf_req, rf_raddr, m_valid);
      end
    end
    rf_gnt = 1'b1;
    @(negedge clk);
    vecs++;
    if (m_valid !== 1'b1 || m_idx !== 5'd7 || m_data !== 32'h1000_0007 ||
        rf_req !== 1'b0) begin
      errs++;
      $display("FAIL gnt beat7: valid %b idx %0d data %h req %b, want 1 7 10000007 0",
               m_valid, m_idx, m_data, rf_req);
    end
    finish_dump(to);
    vecs++;
    if (to) begin
      errs++;
      $display("FAIL gnt end: busy %b, want 0", busy);
    end
  endtask

  task automatic test_start_ignored();
    int e, beats, dones;
    pulse_start();
    e = 0;
    beats = 0;
    dones = 0;
    while (e < 100 && busy) begin
      start = (e == 5 || e == 20 || done);
      if (m_valid) beats++;
      if (done) dones++;
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    vecs++;
    if (beats != 31 || dones != 1) begin
      errs++;
      $display("FAIL start ign: beats %0d dones %0d, want 31 1", beats, dones);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || rf_req !== 1'b0) begin
        errs++;
        $display("FAIL start queued: busy %b req %b, want 0 0", busy, rf_req);
      end
    end
  endtask

  task automatic test_abort();
    int e;
    pulse_start();
    e = 0;
    while (e < 60 && !(m_valid && m_idx == 5'd12)) begin
      @(negedge clk);
      e++;
    end
    vecs++;
    if (!(m_valid === 1'b1 && m_idx === 5'd12)) begin
      errs++;
      $display("FAIL abort reach: valid %b idx %0d, want 1 12", m_valid, m_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vecs++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || rf_req !== 1'b0 ||
        done !== 1'b0) begin
      errs++;
      $display("FAIL abort: valid %b busy %b req %b done %b, want 0 0 0 0",
               m_valid, busy, rf_req, done);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
        errs++;
        $display("FAIL post abort: done %b busy %b valid %b, want 0 0 0",
                 done, busy, m_valid);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int e;
    pulse_start();
    e = 0;
    while (e < 60 && !(m_valid && m_idx == 5'd20)) begin
      @(negedge clk);
      e++;
    end
    vecs++;
    if (!(m_valid === 1'b1 && m_idx === 5'd20)) begin
      errs++;
      $display("FAIL rst reach: valid %b idx %0d, want 1 20", m_valid, m_idx);
    end
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_req !== 1'b0 ||
        rf_raddr !== 6'd0) begin
      errs++;
      $display("FAIL rst ctl: busy %b done %b req %b raddr %0d, want 0 0 0 0",
               busy, done, rf_req, rf_raddr);
    end
    vecs++;
    if (m_valid !== 1'b0 || m_data !== 32'd0 || m_idx !== 5'd0 ||
        m_last !== 1'b0) begin
      errs++;
      $display("FAIL rst beat: valid %b data %h idx %0d last %b, want 0 0 0 0",
               m_valid, m_data, m_idx, m_last);
    end
    @(negedge clk);
    reset = 1'b0;
    test_full_dump();
  endtask

  task automatic test_x0_short();
    int e, beats;
    logic [4:0] exp;
    @(negedge clk);
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    vecs++;
    if (m_valid6 !== 1'b1 || m_idx6 !== 5'd0 || m_data6 !== 32'd0 ||
        rf_req6 !== 1'b0 || m_last6 !== 1'b0) begin
      errs++;
      $display("FAIL x0 beat: valid %b idx %0d data %h req %b last %b, want 1 0 0 0 0",
               m_valid6, m_idx6, m_data6, rf_req6, m_last6);
    end
    @(negedge clk);
    vecs++;
    if (rf_req6 !== 1'b1 || rf_raddr6 !== 6'd1 || m_valid6 !== 1'b0) begin
      errs++;
      $display("FAIL x0 arb1: req %b raddr %0d valid %b, want 1 1 0",
               rf_req6, rf_raddr6, m_valid6);
    end
    e = 1;
    beats = 1;
    exp = 5'd1;
    while (e < 40 && !done6) begin
      if (m_valid6) begin
        vecs++;
        if (m_idx6 !== exp || m_data6 !== rf[exp] ||
            m_last6 !== (exp == 5'd4)) begin
          errs++;
          $display("FAIL x0 walk: idx %0d data %h last %b, want %0d %h %b",
                   m_idx6, m_data6, m_last6, exp, rf[exp], exp == 5'd4);
        end
        beats++;
        exp = exp + 5'd1;
      end
      @(negedge clk);
      e++;
    end
    vecs++;
    if (done6 !== 1'b1 || e != 9 || beats != 5) begin
      errs++;
      $display("FAIL x0 end: done %b at %0d beats %0d, want 1 at 9 beats 5",
               done6, e, beats);
    end
    @(negedge clk);
    vecs++;
    if (busy6 !== 1'b0 || done6 !== 1'b0) begin
      errs++;
      $display("FAIL x0 idle: busy %b done %b, want 0 0", busy6, done6);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + k;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    rf_gnt   = 1'b1;
    m_ready  = 1'b1;
    start6   = 1'b0;
    abort6   = 1'b0;
    rf_gnt6  = 1'b1;
    m_ready6 = 1'b1;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_grant_stall();
    test_start_ignored();
    test_abort();
    test_reset_mid_dump();
    test_x0_short();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
